// File: rtl/pdm_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// pdm_capture_ctrl_if
//   Read-side stream of the PDM capture FIFO (ready/valid).
//   master : the FIFO owner (pdm_capture_ctrl) drives rd_data / rd_valid.
//   slave  : the consumer (CPU/CSR layer) drives rd_ready.
//
//   rd_data  [15:0] FIFO head sample, meaningful only while rd_valid is 1
//   rd_valid        FIFO not empty
//   rd_ready        consumer accepts the head; pops when rd_valid is also 1
// ---------------------------------------------------------------------------
interface pdm_capture_ctrl_if;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;

  modport master (output rd_data, output rd_valid, input rd_ready);
  modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface : pdm_capture_ctrl_if

// File: rtl/pdm_capture_ctrl.sv
// ---------------------------------------------------------------------------
// pdm_capture_ctrl
//   Capture sequencer for the PDM microphone front end. Owns the mic enable
//   and clock-period configuration, discards a programmable number of warm-up
//   samples after a start, and buffers accepted 16-bit PCM samples in a local
//   FIFO drained by the CPU through a ready/valid port.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   start, stop       one-cycle capture start / stop requests (stop wins)
//   period_cfg [7:0]  PDM clock period, latched on an accepted start (>= 2)
//   settle_cfg [15:0] warm-up samples to discard, latched on accepted start
//   irq_level [AW:0]  FIFO fill threshold for irq; 0 disables that term
//   ovf_clear         clears the sticky overflow flag
//   mic_enable        drives pdm_mic.enable (high while WARMUP or RUN)
//   mic_period [7:0]  drives pdm_mic.period
//   pcm_sample [15:0] sample from pdm_mic
//   pcm_valid         sample-valid level from pdm_mic (may stay high long)
//   rd_if             FIFO read stream (rd_data / rd_valid / rd_ready)
//   level [AW:0]      FIFO occupancy, 0..DEPTH
//   busy, running     state != IDLE, state == RUN
//   overflow          sticky: a sample was dropped because the FIFO was full
//   irq               registered level interrupt
// ---------------------------------------------------------------------------
module pdm_capture_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic [7:0]                 period_cfg,
  input  logic [15:0]                settle_cfg,
  input  logic [AW:0]                irq_level,
  input  logic                       ovf_clear,
  output logic                       mic_enable,
  output logic [7:0]                 mic_period,
  input  logic [15:0]                pcm_sample,
  input  logic                       pcm_valid,
  pdm_capture_ctrl_if.master         rd_if,
  output logic [AW:0]                level,
  output logic                       busy,
  output logic                       running,
  output logic                       overflow,
  output logic                       irq
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam logic [AW:0]   DEPTH_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  state_e          state_q, state_d;
  logic            pv_q, pv_d;          // registered pcm_valid for edge detect
  logic            ev_d_q, ev_d_d;      // write strobe, one cycle after event
  logic [7:0]      period_q, period_d;
  logic [15:0]     settle_q, settle_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            overflow_q, overflow_d;
  logic            irq_q, irq_d;

  logic [15:0]     mem [DEPTH];

  logic            start_ok;
  logic            ev;
  logic            pop;
  logic            full;
  logic            push_req;
  logic            push;
  logic            drop;

  // -------------------------------------------------------------------------
  // Control decode
  // -------------------------------------------------------------------------
  // A start is only honoured from IDLE, without a concurrent stop, and with a
  // period that actually toggles the PDM clock.
  assign start_ok = start && !stop && (period_cfg >= 8'd2) && (state_q == ST_IDLE);

  // Rising edge of pcm_valid; events seen while idle are ignored.
  assign ev       = pcm_valid && !pv_q && (state_q != ST_IDLE);

  assign pop      = (level_q != '0) && rd_if.rd_ready;
  assign full     = (level_q == DEPTH_LVL);

  // The strobe only exists for RUN-state events; a stop in the write cycle
  // cancels it.
  assign push_req = ev_d_q && (state_q == ST_RUN) && !stop;

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = (settle_cfg == 16'd0) ? ST_RUN : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (ev && (settle_q == 16'd1)) begin
          // The event that exhausts the settle count is itself discarded.
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy       = (state_q != ST_IDLE);
    running    = (state_q == ST_RUN);
    mic_enable = (state_q != ST_IDLE);
  end

  // -------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------
  always_comb begin
    pv_d       = pcm_valid;
    ev_d_d     = ev && (state_q == ST_RUN);
    period_d   = period_q;
    settle_d   = settle_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;

    if (start_ok) begin
      period_d = period_cfg;
      settle_d = settle_cfg;
    end else if ((state_q == ST_WARMUP) && ev) begin
      settle_d = settle_q - 16'd1;
    end

    if (start_ok) begin
      // Flush: the previous capture's leftovers are discarded.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end

    // Set has priority over clear so a drop in the clear cycle is not lost.
    overflow_d = drop || (overflow_q && !ovf_clear);
    irq_d      = ((irq_level != '0) && (level_q >= irq_level)) || overflow_q;
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q       <= 1'b0;
      ev_d_q     <= 1'b0;
      period_q   <= 8'd0;
      settle_q   <= 16'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      pv_q       <= pv_d;
      ev_d_q     <= ev_d_d;
      period_q   <= period_d;
      settle_q   <= settle_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  // NOTE: the sample storage has no reset; level_q gates every read, so stale
  // contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= pcm_sample;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mic_period     = period_q;
  assign level          = level_q;
  assign overflow       = overflow_q;
  assign irq            = irq_q;
  assign rd_if.rd_valid = (level_q != '0);
  assign rd_if.rd_data  = mem[rd_ptr_q];

endmodule : pdm_capture_ctrl
